// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the core load/store port
// (requester C) and the memory loader/DMA engine (requester L).
//
// Arbitration order, evaluated combinationally every cycle:
//   1. A locked loader burst keeps the port while lReq stays high.
//   2. A loader that has waited MAX_WAIT cycles is force-granted.
//   3. Otherwise the core wins.
//   4. Otherwise an uncontested loader request is granted.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cReq/cWen/cAddr/cWdata/cSize   core request fields
//   cGnt                core access performed this cycle
//   cRdata/cRvalid      registered core read data and its one-cycle valid pulse
//   lReq/lWen/lAddr/lWdata/lSize   loader request fields
//   lLock               loader asks to keep the port across consecutive accesses
//   lGnt                loader access performed this cycle
//   lRdata/lRvalid      registered loader read data and its one-cycle valid pulse
//   memAddr/memWdata/memSize/memWen  muxed request toward dmem
//   memRdata            dmem read data, combinational on memAddr
module dmem_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        cReq,
   input  logic        cWen,
   input  logic [31:0] cAddr,
   input  logic [31:0] cWdata,
   input  logic [2:0]  cSize,
   output logic        cGnt,
   output logic [31:0] cRdata,
   output logic        cRvalid,

   input  logic        lReq,
   input  logic        lWen,
   input  logic [31:0] lAddr,
   input  logic [31:0] lWdata,
   input  logic [2:0]  lSize,
   input  logic        lLock,
   output logic        lGnt,
   output logic [31:0] lRdata,
   output logic        lRvalid,

   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   output logic [2:0]  memSize,
   output logic        memWen,
   input  logic [31:0] memRdata
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_C,
      GNT_L
   } grant_e;

   grant_e grant;

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              lock_active_q, lock_active_d;
   logic [31:0]       c_rdata_q, c_rdata_d;
   logic [31:0]       l_rdata_q, l_rdata_d;
   logic              c_rvalid_q, c_rvalid_d;
   logic              l_rvalid_q, l_rvalid_d;

   // Grant decision. Reset suppresses every grant so nothing reaches
   // dmem while the block is being reset, whatever the requesters do.
   always_comb begin
      grant = GNT_NONE;
      if (!rst) begin
         if (lock_active_q && lReq) begin
            grant = GNT_L;
         end else if ((wait_cnt_q == WAIT_MAX) && lReq) begin
            grant = GNT_L;
         end else if (cReq) begin
            grant = GNT_C;
         end else if (lReq) begin
            grant = GNT_L;
         end
      end
   end

   // Memory-side mux. With no grant the address/data lines follow the
   // core so downstream MMIO decode sees a stable, core-owned address;
   // memWen is forced low so an idle cycle can never write.
   always_comb begin
      cGnt     = (grant == GNT_C);
      lGnt     = (grant == GNT_L);
      memAddr  = cAddr;
      memWdata = cWdata;
      memSize  = cSize;
      memWen   = 1'b0;
      case (grant)
         GNT_C: begin
            memWen = cWen;
         end
         GNT_L: begin
            memAddr  = lAddr;
            memWdata = lWdata;
            memSize  = lSize;
            memWen   = lWen;
         end
         default: begin
            memWen = 1'b0;
         end
      endcase
   end

   // Next-state logic. The wait counter measures how long a pending
   // loader request has been passed over and saturates so the forced
   // grant condition stays true until the loader actually gets in.
   // The lock only arms after a granted locked access, so the first
   // access of a burst still arbitrates normally; it drops as soon as
   // the loader releases either lLock or lReq.
   always_comb begin
      wait_cnt_d    = wait_cnt_q;
      lock_active_d = lock_active_q;
      c_rdata_d     = c_rdata_q;
      l_rdata_d     = l_rdata_q;
      c_rvalid_d    = 1'b0;
      l_rvalid_d    = 1'b0;

      if (lGnt) begin
         wait_cnt_d = '0;
      end else if (lReq && (wait_cnt_q != WAIT_MAX)) begin
         wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end

      if (!lLock || !lReq) begin
         lock_active_d = 1'b0;
      end else if (lGnt) begin
         lock_active_d = 1'b1;
      end

      if (cGnt && !cWen) begin
         c_rdata_d  = memRdata;
         c_rvalid_d = 1'b1;
      end

      if (lGnt && !lWen) begin
         l_rdata_d  = memRdata;
         l_rvalid_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q    <= '0;
         lock_active_q <= 1'b0;
         c_rdata_q     <= '0;
         l_rdata_q     <= '0;
         c_rvalid_q    <= 1'b0;
         l_rvalid_q    <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         lock_active_q <= lock_active_d;
         c_rdata_q     <= c_rdata_d;
         l_rdata_q     <= l_rdata_d;
         c_rvalid_q    <= c_rvalid_d;
         l_rvalid_q    <= l_rvalid_d;
      end
   end

   assign cRdata  = c_rdata_q;
   assign cRvalid = c_rvalid_q;
   assign lRdata  = l_rdata_q;
   assign lRvalid = l_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter with a small word-addressed dmem model.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        cReq, cWen, lReq, lWen, lLock;
   logic [31:0] cAddr, cWdata, lAddr, lWdata;
   logic [2:0]  cSize, lSize;
   logic        cGnt, cRvalid, lGnt, lRvalid;
   logic [31:0] cRdata, lRdata;
   logic [31:0] memAddr, memWdata, memRdata;
   logic [2:0]  memSize;
   logic        memWen;

   int totalChecks = 0;
   int badChecks   = 0;

   logic [31:0] mem [0:255];

   dmem_arbiter #(.MAX_WAIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .cReq     (cReq),
      .cWen     (cWen),
      .cAddr    (cAddr),
      .cWdata   (cWdata),
      .cSize    (cSize),
      .cGnt     (cGnt),
      .cRdata   (cRdata),
      .cRvalid  (cRvalid),
      .lReq     (lReq),
      .lWen     (lWen),
      .lAddr    (lAddr),
      .lWdata   (lWdata),
      .lSize    (lSize),
      .lLock    (lLock),
      .lGnt     (lGnt),
      .lRdata   (lRdata),
      .lRvalid  (lRvalid),
      .memAddr  (memAddr),
      .memWdata (memWdata),
      .memSize  (memSize),
      .memWen   (memWen),
      .memRdata (memRdata)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // dmem model: combinational read, write at the rising edge
   assign memRdata = mem[memAddr[9:2]];

   always @(posedge clk) begin
      if (memWen) begin
         mem[memAddr[9:2]] <= memWdata;
      end
   end

   // Compares one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalChecks++;
      if (obs !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives a full request set at the falling edge, then settles
   task automatic applyStimulus(
      input logic        cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd, input logic [2:0] cs,
      input logic        lr, input logic lw, input logic [31:0] la, input logic [31:0] ld, input logic [2:0] ls,
      input logic        lk
   );
      @(negedge clk);
      cReq = cr; cWen = cw; cAddr = ca; cWdata = cd; cSize = cs;
      lReq = lr; lWen = lw; lAddr = la; lWdata = ld; lSize = ls;
      lLock = lk;
      #1;
   endtask

   // Advances past the next rising edge so registered outputs can be sampled
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      cReq = 0; cWen = 0; cAddr = 0; cWdata = 0; cSize = 0;
      lReq = 0; lWen = 0; lAddr = 0; lWdata = 0; lSize = 0; lLock = 0;

      // ---------------- reset with requests pending ----------------
      applyStimulus(1, 1, 32'h100, 32'h1234, 3'd2, 1, 1, 32'h104, 32'h5678, 3'd2, 1);
      checkOutput("rst_cGnt", {31'b0, cGnt}, 32'd0);
      checkOutput("rst_lGnt", {31'b0, lGnt}, 32'd0);
      checkOutput("rst_memWen", {31'b0, memWen}, 32'd0);
      tick();
      checkOutput("rst_cRdata", cRdata, 32'd0);
      checkOutput("rst_lRdata", lRdata, 32'd0);
      checkOutput("rst_cRvalid", {31'b0, cRvalid}, 32'd0);
      checkOutput("rst_lRvalid", {31'b0, lRvalid}, 32'd0);

      // ---------------- core only ----------------
      applyStimulus(1, 1, 32'h100, 32'hDEADBEEF, 3'd2, 0, 0, 32'h0, 32'h0, 3'd0, 0);
      rst = 1'b0;
      #1;
      checkOutput("core_wr_cGnt", {31'b0, cGnt}, 32'd1);
      checkOutput("core_wr_lGnt", {31'b0, lGnt}, 32'd0);
      checkOutput("core_wr_memWen", {31'b0, memWen}, 32'd1);
      checkOutput("core_wr_memAddr", memAddr, 32'h100);
      checkOutput("core_wr_memWdata", memWdata, 32'hDEADBEEF);
      checkOutput("core_wr_memSize", {29'b0, memSize}, 32'd2);
      tick();
      checkOutput("core_wr_cRvalid", {31'b0, cRvalid}, 32'd0);

      applyStimulus(1, 0, 32'h100, 32'h0, 3'd2, 0, 0, 32'h0, 32'h0, 3'd0, 0);
      checkOutput("core_rd_cGnt", {31'b0, cGnt}, 32'd1);
      checkOutput("core_rd_memWen", {31'b0, memWen}, 32'd0);
      tick();
      checkOutput("core_rd_cRvalid", {31'b0, cRvalid}, 32'd1);
      checkOutput("core_rd_cRdata", cRdata, 32'hDEADBEEF);
      checkOutput("core_rd_lRvalid", {31'b0, lRvalid}, 32'd0);

      // idle: address follows the core, nothing granted, rvalid drops
      applyStimulus(0, 1, 32'h44, 32'h0, 3'd1, 0, 1, 32'h88, 32'h0, 3'd0, 0);
      checkOutput("idle_cGnt", {31'b0, cGnt}, 32'd0);
      checkOutput("idle_lGnt", {31'b0, lGnt}, 32'd0);
      checkOutput("idle_memWen", {31'b0, memWen}, 32'd0);
      checkOutput("idle_memAddr", memAddr, 32'h44);
      tick();
      checkOutput("idle_cRvalid", {31'b0, cRvalid}, 32'd0);
      checkOutput("idle_cRdata_hold", cRdata, 32'hDEADBEEF);

      // preload 0x300 via C and 0x304 via an uncontested L write
      applyStimulus(1, 1, 32'h300, 32'h5A5A0000, 3'd2, 0, 0, 32'h0, 32'h0, 3'd0, 0);
      tick();
      applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 1, 1, 32'h304, 32'hCAFE0001, 3'd2, 0);
      checkOutput("lsolo_lGnt", {31'b0, lGnt}, 32'd1);
      checkOutput("lsolo_memAddr", memAddr, 32'h304);
      checkOutput("lsolo_memWen", {31'b0, memWen}, 32'd1);
      tick();
      checkOutput("lsolo_lRvalid", {31'b0, lRvalid}, 32'd0);

      // ---------------- contention: C wins 4 cycles, then forced L ----------------
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 0, 32'h304, 32'h0, 3'd2, 0);
         checkOutput($sformatf("cont%0d_cGnt", k), {31'b0, cGnt}, {31'b0, (k != 4)});
         checkOutput($sformatf("cont%0d_lGnt", k), {31'b0, lGnt}, {31'b0, (k == 4)});
         tick();
         if (k == 0) checkOutput("cont_cRdata", cRdata, 32'h5A5A0000);
         if (k == 4) begin
            checkOutput("cont_lRvalid", {31'b0, lRvalid}, 32'd1);
            checkOutput("cont_lRdata", lRdata, 32'hCAFE0001);
            checkOutput("cont_cRvalid_off", {31'b0, cRvalid}, 32'd0);
         end
      end

      // idle for two cycles: the wait count (now 1) must hold
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 3'd0, 0);
         checkOutput("hold_grants", {30'b0, cGnt, lGnt}, 32'd0);
         checkOutput("hold_memWen", {31'b0, memWen}, 32'd0);
         tick();
      end

      // resumed contention: with 1 wait already counted, L forced in cycle 3
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 0, 32'h304, 32'h0, 3'd2, 0);
         checkOutput($sformatf("resume%0d_lGnt", k), {31'b0, lGnt}, {31'b0, (k == 3)});
         tick();
      end
      applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 3'd0, 0);
      tick();

      // ---------------- loader lock burst ----------------
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 1, 32'h200, 32'h11, 3'd2, 1);
         checkOutput($sformatf("lockwait%0d_cGnt", k), {31'b0, cGnt}, 32'd1);
         tick();
      end
      applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 1, 32'h200, 32'h11, 3'd2, 1);
      checkOutput("lock0_lGnt", {31'b0, lGnt}, 32'd1);
      tick();
      applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 1, 32'h204, 32'h22, 3'd2, 1);
      checkOutput("lock1_lGnt", {31'b0, lGnt}, 32'd1);
      checkOutput("lock1_cGnt", {31'b0, cGnt}, 32'd0);
      checkOutput("lock1_memAddr", memAddr, 32'h204);
      tick();
      applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 1, 32'h208, 32'h33, 3'd2, 1);
      checkOutput("lock2_lGnt", {31'b0, lGnt}, 32'd1);
      checkOutput("lock2_cGnt", {31'b0, cGnt}, 32'd0);
      tick();
      applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 0, 0, 32'h0, 32'h0, 3'd0, 0);
      checkOutput("unlock_cGnt", {31'b0, cGnt}, 32'd1);
      checkOutput("unlock_lGnt", {31'b0, lGnt}, 32'd0);
      tick();
      checkOutput("burst_mem200", mem[8'h80], 32'h11);
      checkOutput("burst_mem204", mem[8'h81], 32'h22);
      checkOutput("burst_mem208", mem[8'h82], 32'h33);

      // ---------------- read-data isolation ----------------
      applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 32'h200, 32'h0, 3'd2, 0);
      checkOutput("iso_l_lGnt", {31'b0, lGnt}, 32'd1);
      tick();
      checkOutput("iso_l_lRvalid", {31'b0, lRvalid}, 32'd1);
      checkOutput("iso_l_lRdata", lRdata, 32'h11);
      checkOutput("iso_l_cRvalid", {31'b0, cRvalid}, 32'd0);
      checkOutput("iso_l_cRdata", cRdata, 32'h5A5A0000);
      applyStimulus(1, 0, 32'h204, 32'h0, 3'd2, 0, 0, 32'h0, 32'h0, 3'd0, 0);
      tick();
      checkOutput("iso_c_cRvalid", {31'b0, cRvalid}, 32'd1);
      checkOutput("iso_c_cRdata", cRdata, 32'h22);
      checkOutput("iso_c_lRvalid", {31'b0, lRvalid}, 32'd0);
      checkOutput("iso_c_lRdata", lRdata, 32'h11);

      // ---------------- reset during a locked burst ----------------
      applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 1, 1, 32'h210, 32'h44, 3'd2, 1);
      checkOutput("rburst0_lGnt", {31'b0, lGnt}, 32'd1);
      tick();
      applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 1, 32'h214, 32'h55, 3'd2, 1);
      rst = 1'b1;
      #1;
      checkOutput("rburst_rst_memWen", {31'b0, memWen}, 32'd0);
      checkOutput("rburst_rst_grants", {30'b0, cGnt, lGnt}, 32'd0);
      tick();
      checkOutput("rburst_cRdata", cRdata, 32'd0);
      checkOutput("rburst_lRdata", lRdata, 32'd0);
      checkOutput("rburst_rvalids", {30'b0, cRvalid, lRvalid}, 32'd0);
      applyStimulus(1, 0, 32'h300, 32'h0, 3'd2, 1, 1, 32'h214, 32'h55, 3'd2, 1);
      rst = 1'b0;
      #1;
      checkOutput("rburst_post_cGnt", {31'b0, cGnt}, 32'd1);
      checkOutput("rburst_post_lGnt", {31'b0, lGnt}, 32'd0);
      tick();
      checkOutput("rburst_post_cRdata", cRdata, 32'h5A5A0000);

      applyStimulus(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 3'd0, 0);
      tick();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
